// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the multiply/divide controller.
// Operation codes follow the EX-stage funct decode: bit 1 selects divide, bit 0 selects unsigned.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic logic is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 shift-add multiply / restoring divide on magnitudes, with sign fix-up at the output.
// One WIDTH+1-bit adder (plus carry) is shared by both operations.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               div_mode;
    logic               neg_main;
    logic               neg_rem;

    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     add_a;
    logic [WIDTH:0]     add_b;
    logic [WIDTH+1:0]   sum;
    logic               no_borrow;
    logic [2*WIDTH-1:0] acc_neg;

    always_comb begin
        sign_a = is_signed_op(op) & a[WIDTH-1];
        sign_b = is_signed_op(op) & b[WIDTH-1];
        mag_a  = sign_a ? (-a) : a;
        mag_b  = sign_b ? (-b) : b;
    end

    // Divide subtracts via ~d + 1; the carry out of bit WIDTH+1 means no borrow.
    always_comb begin
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        add_a     = div_mode ? rem_shift : {1'b0, acc[2*WIDTH-1:WIDTH]};
        add_b     = div_mode ? ~{1'b0, opb} : (acc[0] ? {1'b0, opb} : '0);
        sum       = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, div_mode};
        no_borrow = sum[WIDTH+1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            opb      <= '0;
            div_mode <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (load) begin
            acc      <= {{WIDTH{1'b0}}, mag_a};
            opb      <= mag_b;
            div_mode <= is_div(op);
            neg_main <= sign_a ^ sign_b;
            neg_rem  <= is_div(op) & sign_a;
        end else if (step) begin
            if (div_mode)
                acc <= {(no_borrow ? sum[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                        acc[WIDTH-2:0], no_borrow};
            else
                acc <= {sum[WIDTH:0], acc[WIDTH-1:1]};
        end
    end

    // Remainder keeps the dividend's sign; quotient/product flip when operand signs differ.
    always_comb begin
        acc_neg = -acc;
        if (div_mode) begin
            res_lo = neg_main ? (-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
            res_hi = neg_rem ? (-acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
        end else begin
            res_lo = neg_main ? acc_neg[WIDTH-1:0] : acc[WIDTH-1:0];
            res_hi = neg_main ? acc_neg[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: owns HI/LO, runs WIDTH datapath steps plus one fix-up
// cycle, and raises busy as a stall request while an operation is in flight.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             div_by_zero;
    logic             load;
    logic             step;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    always_comb begin
        div_by_zero = start && is_div(op) && (b == '0);
        load        = (state == IDLE) && start && !div_by_zero;
        step        = (state == RUN) && !flush;
    end

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .op     (op),
        .a      (a),
        .b      (b),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    // A start in the same cycle as mthi/mtlo takes priority and drops the write.
                    if (start) begin
                        if (div_by_zero) begin
                            div_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            cnt   <= CW'(WIDTH - 1);
                            busy  <= 1'b1;
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: table of arithmetic vectors plus hand-written
// sequences for divide-by-zero, mthi/mtlo, flush and asynchronous reset.
module tb_muldiv_ctrl;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issuing start while busy is illegal by construction; flag it if the bench ever does it.
    always @(posedge clk) begin
        if (reset && start && busy) begin
            checks++;
            errors++;
            $display("FAIL start_while_busy: start=1 busy=1, required start=0 while busy");
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic write_hilo(input logic [W-1:0] hv, input logic [W-1:0] lv);
        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = hv;
        @(negedge clk);
        lo_we = 1'b0;
        wdata = lv;
        hi_we = 1'b0;
        lo_we = 1'b1;
        @(negedge clk);
        lo_we = 1'b0;
        check("hilo_preload_hi", hi, hv);
        check("hilo_preload_lo", lo, lv);
    endtask

    initial begin
        int cyc;

        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
        vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[7] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2};
        vecs[9] = '{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        flush = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;

        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_div_zero", {31'b0, div_zero}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b1;

        // Table-driven arithmetic vectors
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_busy_first", i), {31'b0, busy}, 32'd1);
            wait_idle(cyc);
            check($sformatf("vec%0d_busy_cycles", i), cyc, 32'd33);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
        end

        // Divide by zero: pulse for one cycle, no stall, HI/LO untouched
        write_hilo(32'h11, 32'h22);
        issue(2'b10, 32'd5, 32'd0);
        check("dz_pulse", {31'b0, div_zero}, 32'd1);
        check("dz_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("dz_pulse_end", {31'b0, div_zero}, 32'd0);
        check("dz_busy_after", {31'b0, busy}, 32'd0);
        check("dz_hi", hi, 32'h11);
        check("dz_lo", lo, 32'h22);

        // mthi in IDLE
        hi_we = 1'b1;
        wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_idle", hi, 32'h1234);
        check("mthi_lo_kept", lo, 32'h22);

        // mtlo during RUN is ignored
        issue(2'b01, 32'd6, 32'd7);
        repeat (4) @(negedge clk);
        lo_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_run_lo_hold", lo, 32'h22);
        wait_idle(cyc);
        check("mtlo_run_cycles", cyc, 32'd28);
        check("mtlo_run_hi", hi, 32'd0);
        check("mtlo_run_lo", lo, 32'd42);

        // start together with mthi: start wins, write dropped
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd3;
        b     = 32'd4;
        hi_we = 1'b1;
        wdata = 32'h5555_5555;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        check("start_vs_mthi_busy", {31'b0, busy}, 32'd1);
        check("start_vs_mthi_hi_mid", hi, 32'd0);
        wait_idle(cyc);
        check("start_vs_mthi_hi", hi, 32'd0);
        check("start_vs_mthi_lo", lo, 32'd12);

        // Flush at cycle 10 of multu 6*7
        write_hilo(32'hAA, 32'hBB);
        issue(2'b01, 32'd6, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_hi", hi, 32'hAA);
        check("flush_lo", lo, 32'hBB);
        repeat (40) @(negedge clk);
        check("flush_busy_later", {31'b0, busy}, 32'd0);
        check("flush_hi_later", hi, 32'hAA);
        check("flush_lo_later", lo, 32'hBB);

        // Flush in IDLE has no effect on a following operation
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle_hi", hi, 32'hAA);

        // Asynchronous reset at cycle 10 of multu 6*7
        issue(2'b01, 32'd6, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("areset_busy", {31'b0, busy}, 32'd0);
        check("areset_hi", hi, 32'd0);
        check("areset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("areset_busy_later", {31'b0, busy}, 32'd0);
        check("areset_lo_later", lo, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
